// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM array.
//   PERIOD / TICK_DIV : frame and position-tick lengths of the default 50 MHz build
//   mode_e            : per-channel position source (JOG = switches, TGT = slew to target)
//   clamp()           : limit a value to [lo, hi]
//   step_toward()     : move pos toward tgt by at most step, landing exactly on tgt
package servo_pkg;

  localparam int PERIOD   = 50_000_000 / 50;
  localparam int TICK_DIV = 50_000_000 / 20;

  typedef enum logic {
    JOG = 1'b0,
    TGT = 1'b1
  } mode_e;

  function automatic logic [31:0] clamp(input logic [31:0] val,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (val < lo)      return lo;
    else if (val > hi) return hi;
    else               return val;
  endfunction

  // Differences are taken in the direction that cannot underflow.
  function automatic logic [31:0] step_toward(input logic [31:0] pos,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    if (pos < tgt)      return ((tgt - pos) > step) ? pos + step : tgt;
    else if (pos > tgt) return ((pos - tgt) > step) ? pos - step : tgt;
    else                return pos;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: position, target, mode, shadow duty and PWM comparator.
//   clk, rst      : clock, asynchronous active-high reset
//   tick_i        : position-update strobe (never coincides with ld_i)
//   jog_inc_i/dec : debounced jog levels, sampled on tick_i
//   ld_i          : accepted command for this channel; ld_val_i / ld_imm_i carry it
//   shadow_ld_i   : last clock of the frame; copy pos into the shadow duty
//   ctr_i         : shared frame counter
//   pwm_o         : registered PWM output (ctr < shadow duty)
//   at_target_o   : registered (mode == TGT && pos == target)
//   pos_o         : current position
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int CW        = 20,
  parameter int MIN_CNT   = 25_000,
  parameter int MAX_CNT   = 125_000,
  parameter int STEP_CNT  = 5_000,
  parameter int RESET_CNT = 75_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_i,
  input  logic          jog_inc_i,
  input  logic          jog_dec_i,
  input  logic          ld_i,
  input  logic [CW-1:0] ld_val_i,
  input  logic          ld_imm_i,
  input  logic          shadow_ld_i,
  input  logic [CW-1:0] ctr_i,
  output logic          pwm_o,
  output logic          at_target_o,
  output logic [CW-1:0] pos_o
);

  localparam int EW = CW + 1;
  localparam logic [CW:0] MIN_E  = EW'(MIN_CNT);
  localparam logic [CW:0] MAX_E  = EW'(MAX_CNT);
  localparam logic [CW:0] STEP_E = EW'(STEP_CNT);

  logic [CW-1:0] pos_q, pos_d, tgt_q, tgt_d, dsh_q;
  mode_e         mode_q, mode_d;
  logic          pwm_q, at_q;

  logic [CW:0]   pos_e, inc_e, dec_e;
  logic [CW-1:0] ld_clamped, slew;

  assign pos_e      = {1'b0, pos_q};
  assign inc_e      = pos_e + STEP_E;
  assign dec_e      = pos_e - STEP_E;  // only used once pos >= MIN + STEP
  assign ld_clamped = CW'(clamp(32'(ld_val_i), 32'(MIN_CNT), 32'(MAX_CNT)));
  assign slew       = CW'(step_toward(32'(pos_q), 32'(tgt_q), 32'(STEP_CNT)));

  always_comb begin
    pos_d  = pos_q;
    tgt_d  = tgt_q;
    mode_d = mode_q;
    if (ld_i) begin
      tgt_d  = ld_clamped;
      mode_d = TGT;
      if (ld_imm_i) pos_d = ld_clamped;
    end else if (tick_i) begin
      case ({jog_inc_i, jog_dec_i})
        2'b10: begin
          mode_d = JOG;
          pos_d  = (inc_e > MAX_E) ? MAX_E[CW-1:0] : inc_e[CW-1:0];
        end
        2'b01: begin
          mode_d = JOG;
          pos_d  = (pos_e < MIN_E + STEP_E) ? MIN_E[CW-1:0] : dec_e[CW-1:0];
        end
        2'b00: if (mode_q == TGT) pos_d = slew;
        default: ;  // both pressed: hold, mode unchanged
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= CW'(RESET_CNT);
      tgt_q  <= CW'(RESET_CNT);
      dsh_q  <= CW'(RESET_CNT);
      mode_q <= JOG;
      pwm_q  <= 1'b0;
      at_q   <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      tgt_q  <= tgt_d;
      mode_q <= mode_d;
      // Width changes only between frames so a pulse is never cut short.
      if (shadow_ld_i) dsh_q <= pos_q;
      pwm_q  <= (ctr_i < dsh_q);
      at_q   <= (mode_q == TGT) && (pos_q == tgt_q);
    end
  end

  assign pwm_o       = pwm_q;
  assign at_target_o = at_q;
  assign pos_o       = pos_q;

endmodule

// File: rtl/servo_pwm_array.sv
// N-channel hobby-servo PWM generator with saturating jog and slewed target mode.
//   clk, rst                 : clock, asynchronous active-high reset
//   jog_inc, jog_dec         : per-channel debounced jog levels
//   cmd_valid/cmd_ready      : target command handshake (ready drops on tick cycles)
//   cmd_ch, cmd_val, cmd_imm : channel, requested width, immediate-jump flag
//   cmd_err                  : one-cycle pulse for an accepted out-of-range channel
//   pwm_out, at_target       : per-channel PWM and on-target flags
//   pos_flat                 : channel i position at [i*CW +: CW]
//   frame_start              : one-cycle pulse while the frame counter is 0
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CLK_HZ    = 50_000_000,
  parameter int PWM_HZ    = 50,
  parameter int STEP_HZ   = 20,
  parameter int MIN_CNT   = 25_000,
  parameter int MAX_CNT   = 125_000,
  parameter int STEP_CNT  = 5_000,
  parameter int RESET_CNT = 75_000,
  parameter int CW        = $clog2(CLK_HZ / PWM_HZ + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    jog_inc,
  input  logic [NUM_CH-1:0]    jog_dec,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_ch,
  input  logic [CW-1:0]        cmd_val,
  input  logic                 cmd_imm,
  output logic                 cmd_err,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [NUM_CH-1:0]    at_target,
  output logic [NUM_CH*CW-1:0] pos_flat,
  output logic                 frame_start
);

  localparam int P_PERIOD = CLK_HZ / PWM_HZ;
  localparam int P_TICK   = CLK_HZ / STEP_HZ;
  localparam int DW       = $clog2(P_TICK + 1);

  logic [CW-1:0] ctr_q, ctr_d;
  logic [DW-1:0] div_q, div_d;
  logic          fs_q, err_q;
  logic          tick, accept, ch_ok, shadow_ld;

  assign ctr_d     = (ctr_q == CW'(P_PERIOD - 1)) ? '0 : ctr_q + CW'(1);
  assign div_d     = (div_q == DW'(P_TICK - 1))   ? '0 : div_q + DW'(1);
  assign tick      = (div_q == DW'(P_TICK - 1));
  assign shadow_ld = (ctr_q == CW'(P_PERIOD - 1));

  // Commands are refused on tick cycles so a load and a jog step never
  // compete for the same channel in one clock.
  assign cmd_ready = ~tick;
  assign accept    = cmd_valid & ~tick;
  assign ch_ok     = ({28'd0, cmd_ch} < 32'(NUM_CH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q <= '0;
      div_q <= '0;
      fs_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ctr_q <= ctr_d;
      div_q <= div_d;
      fs_q  <= (ctr_d == '0);
      err_q <= accept & ~ch_ok;
    end
  end

  assign frame_start = fs_q;
  assign cmd_err     = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .CW        (CW),
      .MIN_CNT   (MIN_CNT),
      .MAX_CNT   (MAX_CNT),
      .STEP_CNT  (STEP_CNT),
      .RESET_CNT (RESET_CNT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .jog_inc_i   (jog_inc[i]),
      .jog_dec_i   (jog_dec[i]),
      .ld_i        (accept && ch_ok && (cmd_ch == 4'(i))),
      .ld_val_i    (cmd_val),
      .ld_imm_i    (cmd_imm),
      .shadow_ld_i (shadow_ld),
      .ctr_i       (ctr_q),
      .pwm_o       (pwm_out[i]),
      .at_target_o (at_target[i]),
      .pos_o       (pos_flat[i*CW +: CW])
    );
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array at reduced rates:
// PERIOD = 100 clocks, TICK_DIV = 10 clocks, widths 5..25, step 5, reset 15.
module tb_servo_pwm_array;

  localparam int NCH = 4;
  localparam int CW  = 7;

  logic           clk, rst;
  logic [NCH-1:0] jog_inc, jog_dec;
  logic           cmd_valid, cmd_ready, cmd_imm, cmd_err;
  logic [3:0]     cmd_ch;
  logic [CW-1:0]  cmd_val;
  logic [NCH-1:0] pwm_out, at_target;
  logic [NCH*CW-1:0] pos_flat;
  logic           frame_start;

  servo_pwm_array #(
    .NUM_CH(NCH), .CLK_HZ(1000), .PWM_HZ(10), .STEP_HZ(100),
    .MIN_CNT(5), .MAX_CNT(25), .STEP_CNT(5), .RESET_CNT(15), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .jog_inc(jog_inc), .jog_dec(jog_dec),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_val(cmd_val), .cmd_imm(cmd_imm), .cmd_err(cmd_err),
    .pwm_out(pwm_out), .at_target(at_target), .pos_flat(pos_flat),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks since reset release: the expected frame counter is cyc % 100
  // and a tick is active while cyc % 10 == 9.
  int cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Per-frame PWM width and frame_start accounting (window = samples 1..100).
  int acc [NCH];
  int width [NCH];
  int fs_acc, fs_last, frame_cnt;
  initial begin
    for (int c = 0; c < NCH; c++) begin acc[c] = 0; width[c] = 0; end
    fs_acc = 0; fs_last = 0; frame_cnt = 0;
  end
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) acc[c] = 0;
      fs_acc = 0;
    end else begin
      for (int c = 0; c < NCH; c++) acc[c] = acc[c] + int'(pwm_out[c]);
      fs_acc = fs_acc + int'(frame_start);
      if (cyc % 100 == 0 && cyc > 0) begin
        for (int c = 0; c < NCH; c++) begin width[c] = acc[c]; acc[c] = 0; end
        fs_last = fs_acc;
        fs_acc = 0;
        frame_cnt = frame_cnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int posof(input int ch);
    return int'(pos_flat[ch*CW +: CW]);
  endfunction

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  // Advance to the first sample after the next tick edge.
  task automatic step_tick();
    int n;
    n = 0;
    do begin nclk(); n++; end while (cyc % 10 != 0 && n < 25);
    if (cyc % 10 != 0) chk("tick_timeout", cyc % 10, 0);
  endtask

  task automatic wait_phase(input int m, input int p);
    int n;
    n = 0;
    while (cyc % m != p && n < 250) begin nclk(); n++; end
    if (cyc % m != p) chk("phase_timeout", cyc % m, p);
  endtask

  task automatic wait_frame();
    int f0, n;
    f0 = frame_cnt;
    n = 0;
    while (frame_cnt == f0 && n < 250) begin nclk(); n++; end
    if (frame_cnt == f0) chk("frame_timeout", 0, 1);
  endtask

  task automatic chk_widths(input string nm, input int w0, input int w1,
                            input int w2, input int w3);
    chk({nm, "_w0"}, width[0], w0);
    chk({nm, "_w1"}, width[1], w1);
    chk({nm, "_w2"}, width[2], w2);
    chk({nm, "_w3"}, width[3], w3);
  endtask

  typedef struct {
    int ch;
    int val;
    bit err;
    int exp;
  } vec_t;

  vec_t vec [7];
  int   pos_m [NCH];
  int   exp_inc [5] = '{20, 25, 25, 25, 25};
  int   exp_dec [4] = '{10, 5, 5, 5};

  initial begin
    rst = 1'b1; jog_inc = '0; jog_dec = '0;
    cmd_valid = 1'b0; cmd_ch = '0; cmd_val = '0; cmd_imm = 1'b0;

    // immediate-jump commands: {channel, value, expect cmd_err, expected pos}
    vec[0] = '{3, 100, 1'b0, 25};
    vec[1] = '{7,  10, 1'b1,  0};
    vec[2] = '{0,   0, 1'b0,  5};
    vec[3] = '{1,  17, 1'b0, 17};
    vec[4] = '{15, 20, 1'b1,  0};
    vec[5] = '{2,  24, 1'b0, 24};
    vec[6] = '{3,   3, 1'b0,  5};

    // reset state
    repeat (2) nclk();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_at_target", int'(at_target), 0);
    chk("rst_cmd_err", int'(cmd_err), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    for (int c = 0; c < NCH; c++) chk("rst_pos", posof(c), 15);

    // 1: idle frame
    rst = 1'b0;
    nclk();
    chk("s1_pwm_first", int'(pwm_out), 15);
    wait_frame();
    chk_widths("s1", 15, 15, 15, 15);
    chk("s1_fs_count", fs_last, 1);
    chk("s1_fs_now", int'(frame_start), 1);
    for (int c = 0; c < NCH; c++) chk("s1_pos", posof(c), 15);

    // 2: saturating increase on channel 0
    jog_inc = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      step_tick();
      chk("s2_pos0", posof(0), exp_inc[t]);
    end
    jog_inc = '0;
    chk("s2_pos1", posof(1), 15);
    wait_frame();
    chk_widths("s2_frameA", 15, 15, 15, 15);
    wait_frame();
    chk_widths("s2_frameB", 25, 15, 15, 15);

    // 3: both pressed holds, then saturating decrease on channel 1
    jog_inc = 4'b0010; jog_dec = 4'b0010;
    step_tick();
    chk("s3_both", posof(1), 15);
    jog_inc = '0;
    for (int t = 0; t < 4; t++) begin
      step_tick();
      chk("s3_pos1", posof(1), exp_dec[t]);
    end
    jog_dec = '0;

    // 4: slewed target on channel 2, then jog cancels target mode
    cmd_valid = 1'b1; cmd_ch = 4'd2; cmd_val = 7'd23; cmd_imm = 1'b0;
    chk("s4_ready", int'(cmd_ready), 1);
    nclk();
    cmd_valid = 1'b0;
    chk("s4_pos_hold", posof(2), 15);
    chk("s4_err", int'(cmd_err), 0);
    step_tick();
    chk("s4_slew1", posof(2), 20);
    chk("s4_at_tgt_early", int'(at_target[2]), 0);
    step_tick();
    chk("s4_slew2", posof(2), 23);
    nclk();
    chk("s4_at_tgt", int'(at_target[2]), 1);
    jog_dec = 4'b0100;
    step_tick();
    jog_dec = '0;
    chk("s4_jog_pos", posof(2), 18);
    nclk();
    chk("s4_at_tgt_clr", int'(at_target[2]), 0);
    step_tick();
    chk("s4_no_reslew", posof(2), 18);

    // 5: immediate commands, invalid channels
    pos_m[0] = 25; pos_m[1] = 5; pos_m[2] = 18; pos_m[3] = 15;
    for (int i = 0; i < 7; i++) begin
      if (cyc % 10 == 9) nclk();
      cmd_valid = 1'b1; cmd_ch = 4'(vec[i].ch); cmd_val = 7'(vec[i].val); cmd_imm = 1'b1;
      nclk();
      cmd_valid = 1'b0;
      chk("s5_err_pulse", int'(cmd_err), int'(vec[i].err));
      if (vec[i].err) begin
        for (int c = 0; c < NCH; c++) chk("s5_bad_ch_pos", posof(c), pos_m[c]);
      end else begin
        pos_m[vec[i].ch] = vec[i].exp;
        chk("s5_imm_pos", posof(vec[i].ch), vec[i].exp);
      end
      nclk();
      chk("s5_err_clear", int'(cmd_err), 0);
      if (!vec[i].err) chk("s5_at_tgt", int'(at_target[vec[i].ch]), 1);
    end

    // command presented on a tick cycle is deferred one clock
    wait_phase(10, 9);
    cmd_valid = 1'b1; cmd_ch = 4'd0; cmd_val = 7'd12; cmd_imm = 1'b1;
    chk("s5_tick_ready", int'(cmd_ready), 0);
    nclk();
    chk("s5_tick_hold", posof(0), pos_m[0]);
    chk("s5_tick_ready_back", int'(cmd_ready), 1);
    nclk();
    cmd_valid = 1'b0;
    chk("s5_tick_accept", posof(0), 12);

    // 6: asynchronous reset mid-pulse
    wait_phase(100, 3);
    chk("s6_pwm0_high", int'(pwm_out[0]), 1);
    rst = 1'b1;
    #1;
    chk("s6_pwm_async", int'(pwm_out), 0);
    for (int c = 0; c < NCH; c++) chk("s6_pos_rst", posof(c), 15);
    chk("s6_at_tgt_rst", int'(at_target), 0);
    repeat (3) nclk();
    rst = 1'b0;
    nclk();
    chk("s6_pwm_restart", int'(pwm_out), 15);
    wait_frame();
    chk_widths("s6", 15, 15, 15, 15);
    chk("s6_fs_count", fs_last, 1);
    for (int c = 0; c < NCH; c++) chk("s6_pos", posof(c), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_array.md
Name: servo_pwm_array

Overview:
Parametrised multi-channel hobby-servo PWM generator. It replaces fixed 4-channel, fixed-step jog logic with N channels and a saturating jog mode, plus a slewed target mode loaded over a valid/ready command port. Duty values are double-buffered so a PWM period never glitches mid-pulse. It sits between the debounced switch/accelerometer control logic and the servo output pins.

Parameters:
NUM_CH, 4, number of servo channels (1..16)
CLK_HZ, 50_000_000, input clock frequency
PWM_HZ, 50, PWM frame rate; PERIOD = CLK_HZ/PWM_HZ clocks
STEP_HZ, 20, position-update tick rate; TICK_DIV = CLK_HZ/STEP_HZ clocks
MIN_CNT, 25_000, minimum pulse width in clocks
MAX_CNT, 125_000, maximum pulse width in clocks
STEP_CNT, 5_000, pulse-width change per tick
RESET_CNT, 75_000, pulse width after reset; must lie in [MIN_CNT, MAX_CNT]
CW, $clog2(PERIOD+1), width of counters and position values

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
jog_inc  in  NUM_CH  per-channel level request to increase width (already debounced)
jog_dec  in  NUM_CH  per-channel level request to decrease width
cmd_valid  in  1  target command present
cmd_ready  out  1  command port can accept
cmd_ch  in  4  channel index of the command
cmd_val  in  CW  requested pulse width
cmd_imm  in  1  1 = jump immediately, 0 = slew by STEP_CNT per tick
cmd_err  out  1  one-cycle pulse: command accepted with cmd_ch >= NUM_CH (discarded)
pwm_out  out  NUM_CH  servo PWM outputs
at_target  out  NUM_CH  channel is in target mode and pos == target
pos_flat  out  NUM_CH*CW  current position of each channel; channel i at [i*CW +: CW]
frame_start  out  1  one-cycle pulse when the frame counter is 0

Behaviour:
- Frame counter ctr counts 0..PERIOD-1 and wraps. frame_start = (ctr==0), registered with ctr.
- Tick divider counts 0..TICK_DIV-1. Internal tick pulses for one cycle when the divider wraps.
- Per-channel state: pos, target, mode (JOG/TGT), shadow duty dsh.
- Reset: ctr=0, divider=0, pos=target=dsh=RESET_CNT, mode=JOG, pwm_out=0, at_target=0, cmd_err=0, frame_start=0.
- cmd_ready = ~tick. It is low only on tick cycles, so commands and jog updates never collide.
- A command is accepted when cmd_valid && cmd_ready.
- On accept with a valid channel:
  - target <= clamp(cmd_val, MIN_CNT, MAX_CNT); mode <= TGT.
  - If cmd_imm, pos <= the same clamped value in the same cycle.
- On accept with an invalid channel: nothing changes except cmd_err=1 on the next cycle.
- On tick, per channel, jog_inc/jog_dec sampled:
  - inc&&dec: no change; mode unchanged.
  - inc only: mode <= JOG; pos <= min(pos+STEP_CNT, MAX_CNT). Saturates; never wraps.
  - dec only: mode <= JOG; pos <= max(pos-STEP_CNT, MIN_CNT). Evaluate without unsigned underflow.
  - Neither, mode TGT: pos moves toward target by at most STEP_CNT, landing exactly on target.
  - Neither, mode JOG: hold.
- Jog therefore overrides and cancels target mode.
- Arithmetic is done in CW+1 bits before clamping.
- at_target[i] = (mode==TGT) && (pos==target), registered.
- Shadow load: when ctr==PERIOD-1, dsh[i] <= pos[i]. A new width takes effect at the next frame only.
- pwm_out[i] is registered (ctr < dsh[i]). Output is high for exactly dsh clocks per frame, delayed 1 clock from ctr.
- Reset asserted mid-frame forces pwm_out low immediately (async) and restarts the frame on release.

Decomposition:
- Package servo_pkg holds:
  - localparams PERIOD and TICK_DIV
  - mode encoding JOG=0/TGT=1
  - function clamp(val, lo, hi)
  - function step_toward(pos, tgt, step)
- One sub-module, servo_pwm_channel, holds pos/target/mode/dsh, the comparator and at_target.
- The top holds ctr, the tick divider, command decode and a generate loop of NUM_CH channel instances.

Test Plan:
Sim parameters for all scenarios: CLK_HZ=1000, PWM_HZ=10 (PERIOD=100), STEP_HZ=100 (TICK_DIV=10), MIN=5, MAX=25, STEP=5, RESET=15.
1. Release reset, no inputs -> every pwm_out high exactly 15 clocks per 100-clock frame; frame_start every 100 clocks; pos=15.
2. Hold jog_inc[0] for 5 ticks -> pos0 goes 20,25,25,25,25 (saturates); pwm0 width updates only at frame boundaries; other channels stay at 15.
3. Hold jog_inc[1] and jog_dec[1] together -> pos1 stays 15. Hold jog_dec[1] alone for 4 ticks -> pos1 goes 10,5,5,5.
4. Command ch2, val=23, imm=0 -> pos2 goes 20,23 over two ticks; at_target[2]=1 after reaching 23. Then assert jog_dec[2] at a tick -> pos2=18, at_target[2]=0.
5. Command ch3, val=100, imm=1 -> pos3=25 next cycle (clamped). Command ch=7 -> cmd_err pulses once and no state changes. Drive cmd_valid on a tick cycle -> cmd_ready=0 and acceptance occurs the next cycle.
6. Assert rst mid-frame while pwm_out[0] is high -> pwm_out drops at once; all pos=15 after release; first frame restarts at ctr=0.
